// File: rtl/stream_arb2_if.sv
// -----------------------------------------------------------------------------
// stream_arb2_if
//   Bundle of the two input streams and the merged output stream of the
//   two-input round-robin arbiter stream_arb2.
//
//   Signals (directions as seen by the arbiter):
//     i0_data/i0_valid/i0_last  in   channel 0 beat
//     i0_ready                  out  channel 0 beat accepted this cycle
//     i1_data/i1_valid/i1_last  in   channel 1 beat
//     i1_ready                  out  channel 1 beat accepted this cycle
//     y_data/y_valid/y_last     out  registered output beat
//     y_ready                   in   downstream accepts the output beat
//     s                         out  source index of the held output beat
//
//   Modports:
//     master : the environment (sources of i0/i1, sink of y)
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface stream_arb2_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] i0_data;
   logic             i0_valid;
   logic             i0_last;
   logic             i0_ready;
   logic [WIDTH-1:0] i1_data;
   logic             i1_valid;
   logic             i1_last;
   logic             i1_ready;
   logic [WIDTH-1:0] y_data;
   logic             y_valid;
   logic             y_last;
   logic             y_ready;
   logic             s;

   modport master (
      output i0_data, i0_valid, i0_last,
      output i1_data, i1_valid, i1_last,
      output y_ready,
      input  i0_ready, i1_ready,
      input  y_data, y_valid, y_last, s
   );

   modport slave (
      input  i0_data, i0_valid, i0_last,
      input  i1_data, i1_valid, i1_last,
      input  y_ready,
      output i0_ready, i1_ready,
      output y_data, y_valid, y_last, s
   );
endinterface

// File: rtl/stream_arb2.sv
// -----------------------------------------------------------------------------
// stream_arb2
//   Two-input round-robin stream arbiter with a one-entry registered output
//   stage. Merges channels i0 and i1 into one output stream and reports in `s`
//   which channel the held output beat came from, so a downstream 2-to-1 mux
//   stage can follow the traffic.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : stream_arb2_if.slave (i0/i1 input streams, y output stream, s)
//
//   Parameters:
//     WIDTH : data width of each channel (must match the interface instance)
//
//   Optional feature:
//     STREAM_ARB2_LOCK_EN - when defined, a beat accepted with last = 0 locks
//     the grant to its channel until that channel's last = 1 beat is accepted
//     (packet-atomic arbitration); round-robin preference then only moves at
//     packet boundaries. When undefined, every beat is arbitrated on its own
//     and last is only carried to y_last.
// -----------------------------------------------------------------------------
module stream_arb2 #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   stream_arb2_if.slave bus
);

   logic [WIDTH-1:0] y_data_reg;
   logic             y_valid_reg;
   logic             y_last_reg;
   logic             s_reg;
   // Index of the channel granted most recently; the other one wins a tie.
   logic             pref_reg;

`ifdef STREAM_ARB2_LOCK_EN
   logic             lock_reg;
   logic             lock_ch_reg;
`endif

   logic             load;
   logic             gnt_valid;
   logic             gnt_idx;
   logic             rdy0;
   logic             rdy1;
   logic             accept;
   logic [WIDTH-1:0] gnt_data;
   logic             gnt_last;

   // The output slot can take a beat when empty or when it drains this cycle.
   // Holding readies low during reset keeps upstream beats from being lost.
   assign load = !rst && (!y_valid_reg || bus.y_ready);

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
      if (bus.i0_valid && bus.i1_valid) begin
         gnt_valid = 1'b1;
         gnt_idx   = ~pref_reg;
      end else if (bus.i0_valid) begin
         gnt_valid = 1'b1;
         gnt_idx   = 1'b0;
      end else if (bus.i1_valid) begin
         gnt_valid = 1'b1;
         gnt_idx   = 1'b1;
      end
`ifdef STREAM_ARB2_LOCK_EN
      // While a packet is in flight only its own channel may be granted,
      // even if that channel is momentarily idle.
      if (lock_reg) begin
         gnt_idx   = lock_ch_reg;
         gnt_valid = lock_ch_reg ? bus.i1_valid : bus.i0_valid;
      end
`endif
   end

   assign rdy0   = load && gnt_valid && (gnt_idx == 1'b0) && bus.i0_valid;
   assign rdy1   = load && gnt_valid && (gnt_idx == 1'b1) && bus.i1_valid;
   assign accept = rdy0 || rdy1;

   assign gnt_data = gnt_idx ? bus.i1_data : bus.i0_data;
   assign gnt_last = gnt_idx ? bus.i1_last : bus.i0_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         y_data_reg  <= '0;
         y_valid_reg <= 1'b0;
         y_last_reg  <= 1'b0;
         s_reg       <= 1'b0;
         // Pretend i1 went last so i0 wins the first contention.
         pref_reg    <= 1'b1;
      end else if (accept) begin
         // Covers both fill-into-empty and drain-and-refill in one cycle.
         y_data_reg  <= gnt_data;
         y_valid_reg <= 1'b1;
         y_last_reg  <= gnt_last;
         s_reg       <= gnt_idx;
`ifdef STREAM_ARB2_LOCK_EN
         if (gnt_last) begin
            pref_reg <= gnt_idx;
         end
`else
         pref_reg    <= gnt_idx;
`endif
      end else if (bus.y_ready) begin
         // Drain with nothing to refill: data/last/s keep their last values.
         y_valid_reg <= 1'b0;
      end
   end

`ifdef STREAM_ARB2_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_reg    <= 1'b0;
         lock_ch_reg <= 1'b0;
      end else if (accept) begin
         lock_reg    <= !gnt_last;
         lock_ch_reg <= gnt_idx;
      end
   end
`endif

   assign bus.i0_ready = rdy0;
   assign bus.i1_ready = rdy1;
   assign bus.y_data   = y_data_reg;
   assign bus.y_valid  = y_valid_reg;
   assign bus.y_last   = y_last_reg;
   assign bus.s        = s_reg;

endmodule
